// File: rtl/dma_burst_ctrl.sv
// dma_burst_ctrl: splits one transfer command into 4 KB-safe AXI bursts and streams the beats over the native port
module dma_burst_ctrl #(
  parameter int DMA_DATA_WIDTH = 32,
  parameter int ADDR_W         = 32,
  parameter int LEN_W          = 8,
  parameter int CNT_W          = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        dir,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic [CNT_W-1:0]            word_cnt,
  output logic                        busy,
  output logic                        done,
  input  logic                        s_valid,
  input  logic [DMA_DATA_WIDTH-1:0]   s_data,
  output logic                        s_ready,
  output logic                        m_valid,
  output logic [DMA_DATA_WIDTH-1:0]   m_data,
  input  logic                        m_ready,
  output logic                        valid,
  output logic [ADDR_W-1:0]           address,
  output logic [DMA_DATA_WIDTH-1:0]   wdata,
  output logic [DMA_DATA_WIDTH/8-1:0] wstrb,
  input  logic [DMA_DATA_WIDTH-1:0]   rdata,
  input  logic                        ready,
  output logic [LEN_W-1:0]            dma_len,
  input  logic                        dma_ready
);
  localparam int BYTES = DMA_DATA_WIDTH / 8;
  localparam int OFS   = $clog2(BYTES);
  localparam int BW    = CNT_W + LEN_W + 14;
  typedef enum logic [2:0] {IDLE, CALC, WAIT_DMA, XFER, DRAIN, DONE} state_t;
  state_t            state, state_nx;
  logic              dir_q;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remain;
  logic [LEN_W-1:0]  beat_cnt;
  logic [12:0]       bnd;
  logic [BW-1:0]     span, lim, beats;
  logic              xfer_wr, fire, last;
  always_comb begin
    bnd      = 13'd4096 - {1'b0, addr[11:0]};
    span     = BW'(bnd >> OFS);
    lim      = (BW'(1) << LEN_W) < span ? (BW'(1) << LEN_W) : span;
    beats    = BW'(remain) < lim ? BW'(remain) : lim;
    xfer_wr  = state == XFER && dir_q;
    valid    = state == XFER && (dir_q ? s_valid : !m_valid);
    fire     = valid && ready;
    last     = beat_cnt == dma_len;
    s_ready  = fire && dir_q;
    wdata    = xfer_wr ? s_data : '0;
    wstrb    = xfer_wr ? '1 : '0;
    address  = addr;
    busy     = state != IDLE && state != DONE;
    done     = state == DONE;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = start ? CALC : IDLE;
      CALC:     state_nx = remain == '0 ? DRAIN : WAIT_DMA;
      WAIT_DMA: state_nx = dma_ready ? XFER : WAIT_DMA;
      XFER:     state_nx = fire && last ? CALC : XFER;
      DRAIN:    state_nx = dir_q || !m_valid ? DONE : DRAIN;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      dir_q    <= 1'b0;
      addr     <= '0;
      remain   <= '0;
      beat_cnt <= '0;
      dma_len  <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        dir_q  <= dir;
        addr   <= base_addr & ~ADDR_W'(BYTES - 1);
        remain <= word_cnt;
      end
      if (state == CALC && remain != '0) begin
        dma_len  <= LEN_W'(beats - BW'(1));
        beat_cnt <= '0;
      end
      if (fire) begin
        addr     <= addr + ADDR_W'(BYTES);
        beat_cnt <= beat_cnt + LEN_W'(1);
        if (last) remain <= remain - CNT_W'(dma_len) - CNT_W'(1);
      end
      if (fire && !dir_q) begin
        m_data  <= rdata;
        m_valid <= 1'b1;
      end else if (m_ready) m_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dma_burst_ctrl.sv
// tb_dma_burst_ctrl: directed checks of burst splitting, stream handshakes, empty commands and async reset
module tb_dma_burst_ctrl;
  logic        clk = 0, rst = 1, start = 0, dir = 0;
  logic [31:0] base_addr = 0;
  logic [23:0] word_cnt = 0;
  logic        busy, done, s_valid = 0, s_ready, m_valid, m_ready = 0;
  logic        valid, ready = 0, dma_ready = 0;
  logic [31:0] s_data, m_data, address, wdata, rdata;
  logic [3:0]  wstrb;
  logic [7:0]  dma_len;
  int          n_chk = 0, n_fail = 0;
  int          widx = 0, w0, stall_n;
  logic        clr = 0, cur_dir = 0;
  logic [31:0] aq[$], wq[$], mq[$];
  int          lq[$];
  int          cyc = 0, fires, sr_cnt, done_cnt, bc, bad_strb, vm_viol, last_mhs, done_cyc;

  dma_burst_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .base_addr(base_addr), .word_cnt(word_cnt),
    .busy(busy), .done(done), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .valid(valid), .address(address),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .ready(ready), .dma_len(dma_len), .dma_ready(dma_ready)
  );

  always #5 clk = ~clk;
  assign s_data = 32'hC0DE0000 + widx;
  assign rdata  = address ^ 32'h5A5A0000;
  always @(posedge clk) if (s_ready) widx <= widx + 1;

  always @(negedge clk) begin
    cyc++;
    if (clr) begin
      aq.delete(); wq.delete(); mq.delete(); lq.delete();
      fires = 0; sr_cnt = 0; done_cnt = 0; bc = 0; bad_strb = 0; vm_viol = 0; last_mhs = 0; done_cyc = 0;
    end else begin
      if (valid && ready) begin
        fires++;
        aq.push_back(address);
        if (cur_dir) wq.push_back(wdata);
        if (wstrb != (cur_dir ? 4'hF : 4'h0)) bad_strb++;
        if (bc == 0) lq.push_back(int'(dma_len));
        bc = (bc == int'(dma_len)) ? 0 : bc + 1;
      end
      if (s_ready) sr_cnt++;
      if (m_valid && m_ready) begin
        mq.push_back(m_data);
        last_mhs = cyc;
      end
      if (valid && m_valid) vm_viol++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int bad_seq(logic [31:0] q[$], logic [31:0] b, logic [31:0] step, logic [31:0] x);
    int n = 0;
    for (int i = 0; i < q.size(); i++) if (q[i] != ((b + step * i) ^ x)) n++;
    return n;
  endfunction

  function automatic int at(int q[$], int i);
    return i < q.size() ? q[i] : -1;
  endfunction

  function automatic logic [31:0] ata(logic [31:0] q[$], int i);
    return i < q.size() ? q[i] : 32'hFFFFFFFF;
  endfunction

  task automatic clear_mon();
    clr = 1;
    @(negedge clk);
    #1 clr = 0;
  endtask

  task automatic cmd(logic d, logic [31:0] b, logic [23:0] n);
    @(posedge clk);
    #1;
    dir = d; base_addr = b; word_cnt = n; start = 1; cur_dir = d;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic wait_done(string tag, int lim);
    for (int k = 0; k < lim && done_cnt == 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({tag, "_done"}, done_cnt, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s_valid = 1;
    #1 rst = 0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", valid, 0);
    check("rst_address", address, 0);
    check("rst_wdata", wdata, 0);
    check("rst_wstrb", wstrb, 0);
    check("rst_dma_len", dma_len, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1;

    // 1: single 16-beat write burst
    clear_mon();
    dma_ready = 1; ready = 1; s_valid = 1; w0 = widx;
    cmd(1, 32'h1000, 16);
    wait_done("t1", 100);
    check("t1_fires", fires, 16);
    check("t1_s_ready", sr_cnt, 16);
    check("t1_nbursts", lq.size(), 1);
    check("t1_len", at(lq, 0), 15);
    check("t1_first_addr", ata(aq, 0), 32'h1000);
    check("t1_last_addr", ata(aq, 15), 32'h103C);
    check("t1_addr_seq", bad_seq(aq, 32'h1000, 4, 0), 0);
    check("t1_wdata_seq", bad_seq(wq, 32'hC0DE0000 + w0, 1, 0), 0);
    check("t1_wstrb", bad_strb, 0);

    // 2: 300-word write, second burst gated by dma_ready
    clear_mon();
    dma_ready = 0;
    cmd(1, 32'h0, 300);
    repeat (5) @(negedge clk);
    check("t2_no_dma", fires, 0);
    check("t2_no_valid", valid, 0);
    @(posedge clk); #1 dma_ready = 1;
    @(posedge clk); #1 dma_ready = 0;
    for (int k = 0; k < 400 && fires < 256; k++) @(negedge clk);
    repeat (6) @(negedge clk);
    check("t2_hold_fires", fires, 256);
    check("t2_hold_valid", valid, 0);
    @(posedge clk); #1 dma_ready = 1;
    wait_done("t2", 400);
    check("t2_fires", fires, 300);
    check("t2_nbursts", lq.size(), 2);
    check("t2_len0", at(lq, 0), 255);
    check("t2_len1", at(lq, 1), 43);
    check("t2_burst2_addr", ata(aq, 256), 32'h400);
    check("t2_addr_seq", bad_seq(aq, 32'h0, 4, 0), 0);

    // 3: read across 4 KB boundary
    clear_mon();
    s_valid = 0; m_ready = 1;
    cmd(0, 32'h0FF8, 8);
    wait_done("t3", 100);
    check("t3_words", mq.size(), 8);
    check("t3_data_seq", bad_seq(mq, 32'h0FF8, 4, 32'h5A5A0000), 0);
    check("t3_nbursts", lq.size(), 2);
    check("t3_len0", at(lq, 0), 1);
    check("t3_len1", at(lq, 1), 5);
    check("t3_addr1", ata(aq, 1), 32'h0FFC);
    check("t3_addr2", ata(aq, 2), 32'h1000);
    check("t3_addr7", ata(aq, 7), 32'h1014);
    check("t3_wstrb", bad_strb, 0);

    // 4: read with consumer stall, unaligned base
    clear_mon();
    cmd(0, 32'h2002, 6);
    for (int k = 0; k < 50 && mq.size() < 2; k++) @(negedge clk);
    @(posedge clk); #1 m_ready = 0;
    @(negedge clk);
    stall_n = mq.size();
    repeat (5) @(negedge clk);
    check("t4_stall_words", mq.size(), stall_n);
    check("t4_stall_m_valid", m_valid, 1);
    check("t4_stall_valid", valid, 0);
    @(posedge clk); #1 m_ready = 1;
    wait_done("t4", 100);
    check("t4_words", mq.size(), 6);
    check("t4_data_seq", bad_seq(mq, 32'h2000, 4, 32'h5A5A0000), 0);
    check("t4_done_after_last", done_cyc > last_mhs, 1);
    check("t4_valid_vs_m_valid", vm_viol, 0);

    // 5: zero-length command, repeated start ignored
    clear_mon();
    s_valid = 1;
    @(posedge clk); #1;
    dir = 1; base_addr = 32'h500; word_cnt = 0; start = 1; cur_dir = 1;
    @(posedge clk); #1 word_cnt = 5;
    @(negedge clk);
    check("t5_busy1", busy, 1);
    check("t5_done1", done, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_done2", done, 0);
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    check("t5_done3", done, 1);
    check("t5_busy3", busy, 0);
    @(negedge clk);
    check("t5_done4", done, 0);
    repeat (10) @(negedge clk);
    check("t5_fires", fires, 0);
    check("t5_done_cnt", done_cnt, 1);

    // 6: async reset during transfer, then a clean command
    clear_mon();
    ready = 0;
    cmd(1, 32'h3000, 20);
    for (int k = 0; k < 20 && !valid; k++) @(negedge clk);
    check("t6a_valid_before", valid, 1);
    #2 rst = 0;
    #1;
    check("t6a_valid", valid, 0);
    check("t6a_busy", busy, 0);
    check("t6a_dma_len", dma_len, 0);
    @(posedge clk); #1 rst = 1;
    ready = 1; m_ready = 0;
    cmd(0, 32'h3100, 4);
    for (int k = 0; k < 20 && !m_valid; k++) @(negedge clk);
    check("t6b_m_valid_before", m_valid, 1);
    #2 rst = 0;
    #1;
    check("t6b_m_valid", m_valid, 0);
    check("t6b_m_data", m_data, 0);
    check("t6b_busy", busy, 0);
    @(posedge clk); #1 rst = 1;
    repeat (5) @(negedge clk);
    check("t6_no_done", done_cnt, 0);
    clear_mon();
    m_ready = 1;
    cmd(1, 32'h100, 4);
    wait_done("t6c", 50);
    check("t6c_fires", fires, 4);
    check("t6c_last_addr", ata(aq, 3), 32'h10C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
